// File: rtl/multicycle_ctrl_if.sv
// Fetch-port and data-memory-port handshake bundle between the sequencer and memories.
interface multicycle_ctrl_if;
    logic        fetch_req;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_ready;

    modport master (
        output fetch_req, mem_rd, mem_wr,
        input  fetch_valid, fetch_instr, mem_ready
    );

    modport slave (
        input  fetch_req, mem_rd, mem_wr,
        output fetch_valid, fetch_instr, mem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset sequencer: IF/ID/EX/MEM/WB phase enables, PC and retire count.
module multicycle_ctrl #(
    parameter int              PC_W     = 32,
    parameter int              CNT_W    = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 halt,
    multicycle_ctrl_if.master    bus,
    output logic [31:0]          instr,
    output logic                 decode_en,
    output logic                 alu_en,
    output logic                 reg_we,
    output logic [PC_W-1:0]      pc,
    output logic [CNT_W-1:0]     retired,
    output logic                 illegal,
    output logic [2:0]           state
);
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd7
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_RALU  = 7'b0110011;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [CNT_W-1:0]   ret_q, ret_d;
    logic [31:0]        instr_q, instr_d;
    logic               illegal_q, illegal_d;

    logic               fetch_req_c, mem_rd_c, mem_wr_c;
    logic               is_load, is_store, is_alu, retire;

    assign is_load  = (instr_q[6:0] == OP_LOAD);
    assign is_store = (instr_q[6:0] == OP_STORE);
    assign is_alu   = (instr_q[6:0] == OP_IALU) || (instr_q[6:0] == OP_RALU);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IF;
            pc_q      <= RESET_PC;
            ret_q     <= '0;
            instr_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ret_q     <= ret_d;
            instr_q   <= instr_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        illegal_d   = illegal_q;
        pc_d        = pc_q;
        ret_d       = ret_q;
        retire      = 1'b0;
        fetch_req_c = 1'b0;
        mem_rd_c    = 1'b0;
        mem_wr_c    = 1'b0;
        decode_en   = 1'b0;
        alu_en      = 1'b0;
        reg_we      = 1'b0;

        case (state_q)
            S_IF: begin
                // rst_n gate keeps the request low while reset holds the FSM in IF
                fetch_req_c = !halt && rst_n;
                if (fetch_req_c && bus.fetch_valid) begin
                    instr_d = bus.fetch_instr;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                decode_en = 1'b1;
                if (is_load || is_store || is_alu) begin
                    state_d = S_EX;
                end else begin
                    state_d   = S_ERR;
                    illegal_d = 1'b1;
                end
            end
            S_EX: begin
                alu_en  = 1'b1;
                state_d = (is_load || is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_rd_c = is_load;
                mem_wr_c = is_store;
                if (bus.mem_ready) begin
                    if (is_load) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_IF;
                    end
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                retire  = 1'b1;
                state_d = S_IF;
            end
            S_ERR: state_d = S_ERR;
            default: state_d = S_IF;
        endcase

        if (retire) begin
            pc_d  = pc_q + PC_W'(4);
            ret_d = ret_q + CNT_W'(1);
        end
    end

    assign bus.fetch_req = fetch_req_c;
    assign bus.mem_rd    = mem_rd_c;
    assign bus.mem_wr    = mem_wr_c;
    assign instr         = instr_q;
    assign pc            = pc_q;
    assign retired       = ret_q;
    assign illegal       = illegal_q;
    assign state         = state_q;
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the RV32I core subset: I-type ALU, R-type ALU, loads and stores. It steps every instruction through the IF → ID → EX → (MEM) → (WB) phases, asserting one phase-enable per cycle. It handshakes with the instruction-memory fetch port and the data-memory port, owns the program counter, and counts retired instructions. It sits between the instruction memory and the decoder, register file, ALU and data memory, and replaces free-running fixed-period fetch timing with opcode-dependent sequencing.

## Interface
- PC_W, 32, program counter width
- CNT_W, 32, retired-instruction counter width
- RESET_PC, 0, PC value loaded on reset

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- halt  in  1  suppresses new fetches while high; sampled only in IF
- fetch_req  out  1  fetch request to instruction memory for address pc
- fetch_valid  in  1  fetch_instr is valid; ignored unless fetch_req is high
- fetch_instr  in  32  fetched instruction word
- instr  out  32  latched current instruction, stable from ID until the next fetch
- decode_en  out  1  decoder enable, one cycle in ID
- alu_en  out  1  ALU enable, one cycle in EX
- mem_rd  out  1  data-memory read request (loads)
- mem_wr  out  1  data-memory write request (stores)
- mem_ready  in  1  data-memory done; ignored unless mem_rd or mem_wr is high
- reg_we  out  1  register-file write enable, one cycle in WB
- pc  out  PC_W  current instruction address
- retired  out  CNT_W  retired-instruction count
- illegal  out  1  sticky unsupported-opcode flag
- state  out  3  encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, ERR=7

## Operation
- Reset (async, rst_n=0) sets state=IF, pc=RESET_PC, retired=0, instr=0, illegal=0. All enables are 0 during reset.
- All enables are Moore-decoded from state and instr[6:0]; the only exception is fetch_req, which also depends on halt.
- IF:
  - fetch_req = !halt.
  - On fetch_req && fetch_valid: instr <= fetch_instr, go to ID.
  - Otherwise hold in IF.
- ID: decode_en=1. Classify instr[6:0]:
  - 0000011 load, 0100011 store, 0010011 I-ALU, 0110011 R-ALU → go to EX.
  - Any other value → go to ERR and set illegal=1.
- EX: alu_en=1. Load or store → MEM; ALU op → WB.
- MEM:
  - mem_rd=1 for a load, mem_wr=1 for a store. The request is held until mem_ready.
  - On mem_ready: a load goes to WB; a store retires and goes to IF.
- WB: reg_we=1, then retire and go to IF.
- Retire (same edge as the exit transition): pc <= pc+4, retired <= retired+1.
  - pc wraps modulo 2^PC_W; retired wraps modulo 2^CNT_W.
- ERR: every enable is 0, pc and retired are frozen. The only exit is reset.
- halt does not affect an instruction already past IF; it completes normally.

## Timing
- Minimum cycles per instruction, with fetch_valid and mem_ready asserted in the same cycle as the request:
  - I/R-ALU: 4 (IF, ID, EX, WB)
  - store: 4 (IF, ID, EX, MEM)
  - load: 5 (IF, ID, EX, MEM, WB)
- Each cycle of fetch_valid=0 in IF, or mem_ready=0 in MEM, adds exactly one cycle.
- fetch_valid may arrive in the same cycle fetch_req rises; it is accepted that cycle.
- If halt rises in IF while fetch_valid is high, fetch_req is 0, so the fetch is not accepted and state stays IF.
- A stray fetch_valid outside IF, or a stray mem_ready outside MEM, has no effect.
- pc and retired change only on the retire edge. pc is stable throughout IF, so the address under fetch_req never changes mid-handshake.
- rst_n asserted mid-instruction (e.g. during a MEM stall) immediately drops mem_rd/mem_wr and returns to the reset values; the partial instruction does not retire.

## Test plan
- R-type 0x002081B3 with fetch_valid and mem_ready tied high → states 0,1,2,4,0. reg_we pulses once in cycle 4. pc 0→4, retired 0→1.
- Load 0x0000A103 with mem_ready delayed 3 cycles → mem_rd held 4 cycles, then reg_we for 1 cycle. Total 8 cycles. pc=4.
- Store 0x0020A023 → mem_wr for 1 cycle, no reg_we, state returns to IF after MEM. retired=1, 4 cycles.
- Opcode 0x0000007F → illegal=1, state=7 from the cycle after ID. No further fetch_req, pc unchanged. Only rst_n low clears it.
- halt=1 held for 10 cycles in IF while fetch_valid is high → fetch_req=0, state=0, pc unchanged. On halt=0, the fetch is accepted the same cycle.
- With PC_W=4 and RESET_PC=12, retire one instruction → pc=0 (wrap). Then assert rst_n=0 during a MEM stall → mem_rd drops asynchronously, pc=12, retired=0.
